hazard_stall_controller: RTL and testbench

- Sequences the fetch/decode/execute pipeline registers around the instruction decode stage.
- Branch compare, jump-register and jump-target resolution happen in decode, so this block detects data hazards against EX and MEM and stalls, bubbles or flushes accordingly.
- Also freezes the whole pipeline for multicycle EX operations.
- Sits beside decode; drives the PC write enable, the IF/ID write and flush, and the ID/EX bubble insert.

---
 rtl/hazard_stall_controller_pkg.sv | 18 +
 rtl/hazard_stall_controller_hazard_match.sv | 48 ++++
 rtl/hazard_stall_controller.sv | 146 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the decode-stage hazard/stall controller.
// Optional statistics counters are enabled with `define HAZARD_STATS_EN.
package hazard_stall_controller_pkg;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } state_e;

  localparam int MC_CNT_W = 4;
  localparam int REG_ZERO = 0;

  // Saturating increment for the 32-bit statistics counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_stall_controller_hazard_match.sv
// Combinational register-compare logic: load-use and decode-resolved branch hazards
// against the instructions in EX and MEM. Register 0 never hazards.
module hazard_match
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_branch,
  input  logic                  id_jumpreg,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  ld_hz,
  output logic                  br_hz
);

  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

  function automatic logic reg_match(input logic                  used,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
    return used && (src != ZERO) && (src == dst);
  endfunction

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic rt_early, ex_prod;

  always_comb begin
    rs_ex    = reg_match(id_uses_rs, id_rs, ex_rd);
    rt_ex    = reg_match(id_uses_rt, id_rt, ex_rd);
    rs_mem   = reg_match(id_uses_rs, id_rs, mem_rd);
    rt_mem   = reg_match(id_uses_rt, id_rt, mem_rd);
    // A jump-register only consumes rs early; rt matters for conditional branches.
    rt_early = id_branch && !id_jumpreg;
    ex_prod  = ex_regwrite || ex_memread;
    ld_hz    = ex_memread && (rs_ex || rt_ex);
    br_hz    = (id_branch || id_jumpreg) &&
               ((ex_prod && (rs_ex || (rt_early && rt_ex))) ||
                (mem_memread && (rs_mem || (rt_early && rt_mem))));
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Decode-stage pipeline sequencer: stalls on hazards, redirects on branch/jump,
// freezes for multicycle EX ops. `define HAZARD_STATS_EN adds stall/flush counters.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LAT     = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_branch,
  input  logic                  id_jump,
  input  logic                  id_jumpreg,
  input  logic                  id_branch_taken,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mc_start,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  freeze,
  output logic                  pc_redirect
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  state_e                state_q, state_d;
  logic [MC_CNT_W-1:0]   mc_cnt_q, mc_cnt_d;
  logic                  ld_hz, br_hz, stall, redirect_req;

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_match (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_branch   (id_branch),
    .id_jumpreg  (id_jumpreg),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .mem_memread (mem_memread),
    .mem_rd      (mem_rd),
    .ld_hz       (ld_hz),
    .br_hz       (br_hz)
  );

  assign stall        = ld_hz || br_hz;
  assign redirect_req = id_jump || id_jumpreg || (id_branch && id_branch_taken);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_RUN;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mc_start) begin
          state_d  = ST_FREEZE;
          mc_cnt_d = MC_CNT_W'(MC_LAT - 1);
        end
      end
      ST_FREEZE: begin
        // The cycle that sees mc_cnt=0 is the last frozen one.
        if (mc_cnt_q == '0) state_d = ST_RUN;
        else                mc_cnt_d = mc_cnt_q - 1'b1;
      end
      default: begin
        state_d  = ST_RUN;
        mc_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    pc_redirect = 1'b0;
    if (Reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state_q == ST_FREEZE) begin
      freeze = 1'b1;
    end else if (stall) begin
      idex_bubble = 1'b1;
    end else if (redirect_req) begin
      pc_redirect = 1'b1;
      pc_write    = 1'b1;
      ifid_flush  = 1'b1;
      ifid_write  = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Outside reset, idex_bubble is asserted only by a stall and pc_redirect only by a redirect.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (freeze || idex_bubble) stall_cycles_d = sat_inc32(stall_cycles_q);
    if (pc_redirect)           flush_count_d  = sat_inc32(flush_count_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios plus randomized traffic
// against a cycle-level reference model of the pipeline-control rules.
module tb_hazard_stall_controller;

  localparam int REG_ADDR_W = 5;
  localparam int MC_LAT     = 4;

  logic                  Clk = 1'b0;
  logic                  Reset;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic                  id_uses_rs, id_uses_rt, id_branch, id_jump, id_jumpreg;
  logic                  id_branch_taken, ex_regwrite, ex_memread, mem_memread, mc_start;
  logic                  pc_write, ifid_write, ifid_flush, idex_bubble, freeze, pc_redirect;
`ifdef HAZARD_STATS_EN
  logic [31:0]           stall_cycles, flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_freeze_left = 0;
  logic [31:0] m_stall_cnt   = '0;
  logic [31:0] m_flush_cnt   = '0;
  logic [5:0]  m_exp;

  always #5 Clk = ~Clk;

  hazard_stall_controller #(
    .REG_ADDR_W (REG_ADDR_W),
    .MC_LAT     (MC_LAT)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_branch       (id_branch),
    .id_jump         (id_jump),
    .id_jumpreg      (id_jumpreg),
    .id_branch_taken (id_branch_taken),
    .ex_regwrite     (ex_regwrite),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .mem_memread     (mem_memread),
    .mem_rd          (mem_rd),
    .mc_start        (mc_start),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .freeze          (freeze),
    .pc_redirect     (pc_redirect)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A source register is "hit" by a producer if it is read, nonzero, and equal.
  function automatic bit hits(bit used, int src, int dst);
    return used && (src != 0) && (src == dst);
  endfunction

  function automatic bit model_stall();
    bit early_rt, load_use, early_need;
    load_use = ex_memread && (hits(id_uses_rs, id_rs, ex_rd) || hits(id_uses_rt, id_rt, ex_rd));
    early_rt = id_branch && !id_jumpreg;
    early_need = 0;
    if (id_branch || id_jumpreg) begin
      if ((ex_regwrite || ex_memread) &&
          (hits(id_uses_rs, id_rs, ex_rd) || (early_rt && hits(id_uses_rt, id_rt, ex_rd))))
        early_need = 1;
      if (mem_memread &&
          (hits(id_uses_rs, id_rs, mem_rd) || (early_rt && hits(id_uses_rt, id_rt, mem_rd))))
        early_need = 1;
    end
    return load_use || early_need;
  endfunction

  // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, freeze, pc_redirect}
  function automatic logic [5:0] model_outs();
    if (Reset)                  return 6'b001100;
    if (m_freeze_left > 0)      return 6'b000010;
    if (model_stall())          return 6'b000100;
    if (id_jump || id_jumpreg || (id_branch && id_branch_taken))
                                return 6'b111001;
    return 6'b110000;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Compare outputs at the falling edge, then advance the model across the next rising edge.
  task automatic eval();
    @(negedge Clk);
    m_exp = model_outs();
    check_eq("outs", {26'd0, pc_write, ifid_write, ifid_flush, idex_bubble, freeze, pc_redirect},
             {26'd0, m_exp});
`ifdef HAZARD_STATS_EN
    check_eq("stall_cycles", stall_cycles, m_stall_cnt);
    check_eq("flush_count", flush_count, m_flush_cnt);
`endif
    if (Reset) begin
      m_freeze_left = 0;
      m_stall_cnt   = '0;
      m_flush_cnt   = '0;
    end else begin
      if (m_exp[2] || m_exp[1]) m_stall_cnt = (m_stall_cnt == 32'hFFFF_FFFF) ? m_stall_cnt : m_stall_cnt + 1;
      if (m_exp[0])             m_flush_cnt = (m_flush_cnt == 32'hFFFF_FFFF) ? m_flush_cnt : m_flush_cnt + 1;
      if (m_freeze_left > 0)    m_freeze_left--;
      else if (mc_start)        m_freeze_left = MC_LAT;
    end
  endtask

  task automatic idle_inputs();
    Reset = 0; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_branch = 0; id_jump = 0; id_jumpreg = 0; id_branch_taken = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = '0; mem_memread = 0; mem_rd = '0; mc_start = 0;
  endtask

  int nfrz;

  initial begin
    idle_inputs();
    Reset = 1;
    tick(); eval();
    check_eq("rst_pc_write", pc_write, 0);
    check_eq("rst_flush", ifid_flush, 1);
    tick(); Reset = 1; eval();

    // Load feeding an ALU op: one bubble, then normal
    tick(); idle_inputs(); ex_memread = 1; ex_regwrite = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1; eval();
    check_eq("ld_use_stall", {pc_write, idex_bubble}, 2'b01);
    tick(); ex_memread = 0; ex_regwrite = 0; mem_memread = 1; mem_rd = 8; eval();
    check_eq("ld_use_after", {pc_write, idex_bubble}, 2'b10);

    // Load feeding a taken beq on rt: two stalls, then redirect
    tick(); idle_inputs(); ex_memread = 1; ex_regwrite = 1; ex_rd = 9;
    id_branch = 1; id_branch_taken = 1; id_rt = 9; id_uses_rt = 1; id_rs = 3; id_uses_rs = 1; eval();
    check_eq("ld_br_stall1", idex_bubble, 1);
    tick(); ex_memread = 0; ex_regwrite = 0; mem_memread = 1; mem_rd = 9; eval();
    check_eq("ld_br_stall2", idex_bubble, 1);
    tick(); mem_memread = 0; mem_rd = 0; eval();
    check_eq("ld_br_redirect", {pc_redirect, ifid_flush}, 2'b11);

    // Register 0 never hazards
    tick(); idle_inputs(); ex_regwrite = 1; ex_rd = 0; id_branch = 1; id_uses_rs = 1; id_rs = 0; eval();
    check_eq("r0_no_stall", pc_write, 1);

    // jr on ALU result: one stall, then redirect
    tick(); idle_inputs(); id_jumpreg = 1; id_uses_rs = 1; id_rs = 31; ex_regwrite = 1; ex_rd = 31; eval();
    check_eq("jr_stall", idex_bubble, 1);
    tick(); ex_regwrite = 0; ex_rd = 0; mem_rd = 31; eval();
    check_eq("jr_redirect", {pc_redirect, ifid_flush}, 2'b11);

    // Multicycle freeze with a hazard pending throughout
    tick(); idle_inputs(); mc_start = 1; eval();
    check_eq("mc_start_cycle", freeze, 0);
    nfrz = 0;
    for (int i = 0; i < MC_LAT + 2; i++) begin
      tick(); idle_inputs(); ex_memread = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1; mc_start = (i == 1); eval();
      if (freeze) begin
        nfrz++;
        check_eq("frz_no_bubble", idex_bubble, 0);
      end
    end
    check_eq("freeze_len", nfrz, MC_LAT);

    // Reset on the second freeze cycle aborts the freeze
    tick(); idle_inputs(); mc_start = 1; eval();
    tick(); mc_start = 0; eval();
    check_eq("frz1", freeze, 1);
    tick(); Reset = 1; eval();
    check_eq("frz_rst_outs", {pc_write, ifid_write, ifid_flush, idex_bubble, freeze, pc_redirect}, 6'b001100);
    tick(); Reset = 0; eval();
    check_eq("post_rst_run", {pc_write, freeze}, 2'b10);
`ifdef HAZARD_STATS_EN
    check_eq("post_rst_stats", stall_cycles | flush_count, 0);
`endif

    // Randomized traffic with small register numbers to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      tick();
      Reset           = ($urandom_range(0, 59) == 0);
      id_rs           = REG_ADDR_W'($urandom_range(0, 3));
      id_rt           = REG_ADDR_W'($urandom_range(0, 3));
      ex_rd           = REG_ADDR_W'($urandom_range(0, 3));
      mem_rd          = REG_ADDR_W'($urandom_range(0, 3));
      id_uses_rs      = $urandom_range(0, 1);
      id_uses_rt      = $urandom_range(0, 1);
      id_branch       = ($urandom_range(0, 2) == 0);
      id_jump         = ($urandom_range(0, 7) == 0);
      id_jumpreg      = ($urandom_range(0, 7) == 0);
      id_branch_taken = $urandom_range(0, 1);
      ex_regwrite     = $urandom_range(0, 1);
      ex_memread      = ($urandom_range(0, 2) == 0);
      mem_memread     = ($urandom_range(0, 2) == 0);
      mc_start        = ($urandom_range(0, 11) == 0);
      eval();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
